// File: rtl/pico_arb_pkg.sv
// Shared types and constants for the two-master PicoRV32 memory-port arbiter.
package pico_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef logic [1:0] grant_t;

  // Fill bit replicated across rdata when a transfer is ended by the stall timer.
  localparam logic TIMEOUT_RDATA = 1'b0;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  function automatic grant_t state_grant(input arb_state_t st);
    grant_t g;
    g = 2'b00;
    if (st == GNT0) g = 2'b01;
    if (st == GNT1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/pico_arb_timeout.sv
// Per-transfer stall timer: cleared while idle or on completion, counts stalled
// granted cycles and flags expiry on the TIMEOUT-th stall cycle.
module pico_arb_timeout #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] r_cnt;

      // Saturates at TIMEOUT so a missed clear can never wrap back into range.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_expire = i_en && (r_cnt == CNT_LAST);
    end else begin : g_off
      logic w_unused_tie;
      assign w_unused_tie = ^{clk, resetn, i_clr, i_en};
      assign o_expire     = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pico_mem_arbiter.sv
// Two-master arbiter in front of one PicoRV32 native memory port.
//   state | meaning
//   IDLE  | no owner, all shared-port outputs zero
//   GNT0  | master 0 (core) owns the port until completion, abort or timeout
//   GNT1  | master 1 (loader/debug) owns the port until completion, abort or timeout
module pico_mem_arbiter
  import pico_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,

  output logic [1:0]          grant,
  output logic                timeout_err
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic       r_timeout_err;

  logic w_gnt0;
  logic w_gnt1;
  logic w_busy;
  logic w_done;
  logic w_stall;
  logic w_expire;
  logic w_fin;
  logic w_tmr_clr;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);
  assign w_busy = w_gnt0 | w_gnt1;

  always_comb begin
    s_valid = 1'b0;
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (w_gnt0) begin
      s_valid = m0_valid;
      s_instr = m0_instr;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (w_gnt1) begin
      s_valid = m1_valid;
      s_instr = m1_instr;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
  end

  assign w_done    = s_valid & s_ready;
  assign w_stall   = w_busy & s_valid & ~s_ready;
  assign w_fin     = w_done | w_expire;
  assign w_tmr_clr = ~w_busy | w_fin;

  pico_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .i_clr    (w_tmr_clr),
    .i_en     (w_stall),
    .o_expire (w_expire)
  );

  // A timed-out transfer is completed towards the master with a fixed data word.
  assign m0_ready = w_gnt0 & (s_ready | w_expire);
  assign m1_ready = w_gnt1 & (s_ready | w_expire);
  assign m0_rdata = !w_gnt0 ? '0 : (w_expire ? {DATA_W{TIMEOUT_RDATA}} : s_rdata);
  assign m1_rdata = !w_gnt1 ? '0 : (w_expire ? {DATA_W{TIMEOUT_RDATA}} : s_rdata);

  assign grant       = state_grant(r_state);
  assign timeout_err = r_timeout_err;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          if ((FIXED_PRIO != 0) || (r_last == LAST_M1)) w_state_nxt = GNT0;
          else                                          w_state_nxt = GNT1;
        end else if (m0_valid) begin
          w_state_nxt = GNT0;
        end else if (m1_valid) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (w_fin) begin
          w_last_nxt  = LAST_M0;
          w_state_nxt = m1_valid ? GNT1 : IDLE;
        end else if (!m0_valid) begin
          w_state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (w_fin) begin
          w_last_nxt  = LAST_M1;
          w_state_nxt = m0_valid ? GNT0 : IDLE;
        end else if (!m1_valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_last        <= LAST_M1;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      if (w_expire) r_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pico_mem_arbiter.sv
// Scoreboard bench for pico_mem_arbiter: round-robin/timeout instance plus a
// fixed-priority instance sharing the same master stimulus.
module tb_pico_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        resetn_fp;

  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        m0_ready, m1_ready, s_valid, s_instr, s_ready, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr, fp_s_ready, fp_timeout_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata, fp_s_rdata;
  logic [3:0]  fp_s_wstrb;
  logic [1:0]  fp_grant;

  int mem_wait = 2;
  logic mem_hang = 1'b0;
  int wcnt, fp_wcnt;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pico_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  pico_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .resetn(resetn_fp),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_wstrb(fp_s_wstrb), .s_ready(fp_s_ready), .s_rdata(fp_s_rdata),
    .grant(fp_grant), .timeout_err(fp_timeout_err)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0010_0093;
    return {a[15:0], 16'hBEEF};
  endfunction

  // Memory model: mem_wait stall cycles, then a one-cycle ready; mem_hang never answers.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_ready <= 1'b0;
      wcnt    <= 0;
    end else if (s_valid && !s_ready) begin
      if (!mem_hang && wcnt == mem_wait - 1) s_ready <= 1'b1;
      else                                   wcnt    <= wcnt + 1;
    end else begin
      s_ready <= 1'b0;
      wcnt    <= 0;
    end
  end
  assign s_rdata = (s_ready && s_wstrb == 4'h0) ? mem_rd(s_addr) : 32'h0;

  always @(posedge clk or negedge resetn_fp) begin
    if (!resetn_fp) begin
      fp_s_ready <= 1'b0;
      fp_wcnt    <= 0;
    end else if (fp_s_valid && !fp_s_ready) begin
      if (fp_wcnt == mem_wait - 1) fp_s_ready <= 1'b1;
      else                         fp_wcnt    <= fp_wcnt + 1;
    end else begin
      fp_s_ready <= 1'b0;
      fp_wcnt    <= 0;
    end
  end
  assign fp_s_rdata = (fp_s_ready && fp_s_wstrb == 4'h0) ? mem_rd(fp_s_addr) : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic push_exp(input int m, input logic [31:0] a, input logic [31:0] rd);
    exp_t e;
    e.m = m; e.addr = a; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Monitor: every master completion pops the next expected response.
  always @(negedge clk) begin
    if (resetn && (m0_ready || m1_ready)) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_ready: got m0_ready=%0b m1_ready=%0b, required none", m0_ready, m1_ready);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_single_ready", {31'b0, m0_ready & m1_ready}, 32'h0);
        chk("sb_master", m1_ready ? 32'd1 : 32'd0, e.m);
        chk("sb_grant", {30'b0, grant}, (e.m == 1) ? 32'h2 : 32'h1);
        chk("sb_addr", s_addr, e.addr);
        chk("sb_instr", {31'b0, s_instr}, (e.m == 0) ? 32'h1 : 32'h0);
        chk("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end

  task automatic wait_ready(input int m, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if ((m == 0) ? m0_ready : m1_ready) return;
    end
    n_chk++;
    $display("FAIL ready_wait_m%0d: got no ready, required ready within 40 cycles", m);
    n = -1;
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output int n);
    @(posedge clk); #1;
    if (m == 0) begin
      m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = 1'b1; m0_valid = 1'b1;
    end else begin
      m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = 1'b0; m1_valid = 1'b1;
    end
    wait_ready(m, n);
    @(posedge clk); #1;
    if (m == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, n1, nx;
    resetn = 1'b0; resetn_fp = 1'b0;
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h10; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0;    m1_wdata = '0; m1_wstrb = '0;

    repeat (10) @(negedge clk);
    chk("rst_s_valid", {31'b0, s_valid}, 32'h0);
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
    push_exp(0, 32'h10, 32'h0010_0093);
    resetn = 1'b1; resetn_fp = 1'b1;
    @(negedge clk);
    chk("rst_release_grant", {30'b0, grant}, 32'h1);
    wait_ready(0, n);
    @(posedge clk); #1;
    m0_valid = 1'b0;

    // single read with two wait states
    push_exp(0, 32'h10, 32'h0010_0093);
    issue(0, 32'h10, 32'h0, 4'h0, n);
    chk("read_latency", n, 32'd4);
    @(negedge clk);
    chk("read_ready_pulse", {31'b0, m0_ready}, 32'h0);
    chk("read_m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("read_idle_grant", {30'b0, grant}, 32'h0);

    // back-to-back hand-over to a pending m1 write
    push_exp(0, 32'h14, 32'h0014_BEEF);
    push_exp(1, 32'h100, 32'h0);
    fork
      issue(0, 32'h14, 32'h0, 4'h0, n0);
      begin @(posedge clk); issue(1, 32'h100, 32'hCAFE_F00D, 4'hF, n1); end
      begin
        wait_ready(0, nx);
        chk("b2b_grant_done", {30'b0, grant}, 32'h1);
        @(negedge clk);
        chk("b2b_grant_next", {30'b0, grant}, 32'h2);
        chk("b2b_s_valid", {31'b0, s_valid}, 32'h1);
        chk("b2b_s_addr", s_addr, 32'h100);
        chk("b2b_s_wdata", s_wdata, 32'hCAFE_F00D);
        chk("b2b_s_wstrb", {28'b0, s_wstrb}, 32'hF);
      end
    join

    // simultaneous requests from idle, last owner m1: 01,10,01,10
    push_exp(0, 32'h20,  32'h0020_BEEF);
    push_exp(1, 32'h200, 32'h0200_BEEF);
    push_exp(0, 32'h24,  32'h0024_BEEF);
    push_exp(1, 32'h204, 32'h0204_BEEF);
    fork
      begin issue(0, 32'h20, 32'h0, 4'h0, n0);  issue(0, 32'h24, 32'h0, 4'h0, n0);  end
      begin issue(1, 32'h200, 32'h0, 4'h0, n1); issue(1, 32'h204, 32'h0, 4'h0, n1); end
    join

    // last owner m0, then a tie: round-robin picks m1, fixed priority picks m0
    push_exp(0, 32'h30, 32'h0030_BEEF);
    issue(0, 32'h30, 32'h0, 4'h0, n);
    push_exp(1, 32'h300, 32'h0300_BEEF);
    push_exp(0, 32'h34,  32'h0034_BEEF);
    fork
      issue(0, 32'h34, 32'h0, 4'h0, n0);
      issue(1, 32'h300, 32'h0, 4'h0, n1);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rr_tie_grant", {30'b0, grant}, 32'h2);
        chk("fp_tie_grant", {30'b0, fp_grant}, 32'h1);
      end
    join
    resetn_fp = 1'b0;

    // stall timeout after 8 cycles
    chk("timeout_err_pre", {31'b0, timeout_err}, 32'h0);
    mem_hang = 1'b1;
    push_exp(0, 32'h40, 32'h0);
    issue(0, 32'h40, 32'h0, 4'h0, n);
    chk("timeout_latency", n, 32'd9);
    chk("timeout_err_set", {31'b0, timeout_err}, 32'h1);
    mem_hang = 1'b0;
    push_exp(1, 32'h50, 32'h0050_BEEF);
    issue(1, 32'h50, 32'h0, 4'h0, n);
    chk("post_timeout_latency", n, 32'd4);
    chk("timeout_err_sticky", {31'b0, timeout_err}, 32'h1);

    // asynchronous reset in the middle of a stalled m1 transfer
    mem_hang = 1'b1;
    @(posedge clk); #1;
    m1_addr = 32'h60; m1_wstrb = 4'h0; m1_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_grant_before", {30'b0, grant}, 32'h2);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_s_valid", {31'b0, s_valid}, 32'h0);
    chk("midrst_grant", {30'b0, grant}, 32'h0);
    chk("midrst_m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("midrst_timeout_err", {31'b0, timeout_err}, 32'h0);
    m1_valid = 1'b0;
    mem_hang = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_idle_grant", {30'b0, grant}, 32'h0);
    chk("midrst_err_after", {31'b0, timeout_err}, 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
